display_timing_counters: RTL and testbench

Counter and sync-timing stage directly upstream of `display_controller`. It owns the pixel, line, vertical-blank and two buffer-address counters that the controller steps through its `IncPx/ResetPx`, `IncLine/ResetLine`, `SyncVB`, `IncAddr0/ResetAddr0` and `IncAddr1/ResetAddr1` strobes. It returns the counts on `Pxout`, `Lineout`, `VBout`, `AIPout` and `AILout`. It also tracks the vertical phase with an FSM and generates registered hsync/vsync for the panel.

---
 rtl/disp_pkg.sv | 31 +++
 rtl/disp_mod_counter.sv | 45 ++++
 rtl/display_timing_counters.sv | 155 +++++++++++++++
 tb/tb_display_timing_counters.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg
// Shared types and default timing for the display counter stage.
//   CNT_W            width of every counter output
//   DEF_*            default 640x480 panel timing (pixels / lines)
//   DEF_H_TOTAL      full line length in pixels
//   DEF_V_TOTAL      full frame length in lines
//   vstate_t         vertical phase of the frame
package disp_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    V_ACT   = 2'd0,
    V_FRONT = 2'd1,
    V_SYN   = 2'd2,
    V_BACK  = 2'd3
  } vstate_t;

endpackage

// File: rtl/disp_mod_counter.sv
// disp_mod_counter
// Wrap-limit up counter: counts 0..LIMIT-1 and wraps to 0, pulsing wrap for
// one cycle on the wrapping edge. A clear request beats an increment and
// never produces a wrap pulse.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   inc    step the count by one
//   clr    force the count to zero
//   count  current count
//   wrap   one-cycle pulse on the LIMIT-1 -> 0 transition
module disp_mod_counter #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 800
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        if (count == LAST) begin
          count <= '0;
          wrap  <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/display_timing_counters.sv
// display_timing_counters
// Pixel, line, vertical-blank and two buffer-address counters stepped by the
// display controller's strobes, plus a vertical-phase FSM and the panel syncs.
// Configuration macro: DISP_SYNC_OUT_EN
//   defined   -> registered hsync_n / vsync_n generated from counters and FSM
//   undefined -> hsync_n / vsync_n tied high, hsync comparator not built
// Ports:
//   clock, reset (async, active-low)
//   IncPx/ResetPx, IncLine/ResetLine, SyncVB,
//   IncAddr0/ResetAddr0, IncAddr1/ResetAddr1   controller strobes
//   Pxout, Lineout, VBout, AIPout, AILout        counter values
//   line_done, frame_done, addr0_wrap, addr1_wrap one-cycle wrap pulses
//   hsync_n, vsync_n                             active-low panel syncs
//   vblank                                       high outside visible lines
module display_timing_counters
  import disp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             IncPx,
  input  logic             ResetPx,
  input  logic             IncLine,
  input  logic             ResetLine,
  input  logic             SyncVB,
  input  logic             IncAddr0,
  input  logic             ResetAddr0,
  input  logic             IncAddr1,
  input  logic             ResetAddr1,
  output logic [CNT_W-1:0] Pxout,
  output logic [CNT_W-1:0] Lineout,
  output logic [CNT_W-1:0] VBout,
  output logic [CNT_W-1:0] AIPout,
  output logic [CNT_W-1:0] AILout,
  output logic             line_done,
  output logic             frame_done,
  output logic             addr0_wrap,
  output logic             addr1_wrap,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_FRONT_AT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYN_AT    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_BACK_AT   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] VB_MAX      = CNT_W'(V_TOTAL - V_ACTIVE);

  vstate_t          state;
  vstate_t          state_next;
  logic [CNT_W-1:0] line_next;

  disp_mod_counter #(.WIDTH(CNT_W), .LIMIT(H_TOTAL)) u_px (
    .clock (clock), .reset (reset), .inc (IncPx), .clr (ResetPx),
    .count (Pxout), .wrap (line_done)
  );

  disp_mod_counter #(.WIDTH(CNT_W), .LIMIT(V_TOTAL)) u_line (
    .clock (clock), .reset (reset), .inc (IncLine), .clr (ResetLine),
    .count (Lineout), .wrap (frame_done)
  );

  disp_mod_counter #(.WIDTH(CNT_W), .LIMIT(H_ACTIVE)) u_addr0 (
    .clock (clock), .reset (reset), .inc (IncAddr0), .clr (ResetAddr0),
    .count (AIPout), .wrap (addr0_wrap)
  );

  disp_mod_counter #(.WIDTH(CNT_W), .LIMIT(H_ACTIVE)) u_addr1 (
    .clock (clock), .reset (reset), .inc (IncAddr1), .clr (ResetAddr1),
    .count (AILout), .wrap (addr1_wrap)
  );

  // The FSM looks at the line value the counter is about to take, so this
  // mirrors the line counter's reset-over-inc and wrap behaviour.
  always_comb begin
    line_next = Lineout;
    if (ResetLine) begin
      line_next = '0;
    end else if (IncLine) begin
      line_next = (Lineout == V_LAST) ? '0 : Lineout + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= V_ACT;
    end else begin
      state <= state_next;
    end
  end

  // ResetLine beats SyncVB; otherwise phases only advance on a line step.
  always_comb begin
    state_next = state;
    if (ResetLine) begin
      state_next = V_ACT;
    end else if (SyncVB) begin
      state_next = V_FRONT;
    end else if (IncLine) begin
      case (state)
        V_ACT:   if (line_next == V_FRONT_AT) state_next = V_FRONT;
        V_FRONT: if (line_next == V_SYN_AT)   state_next = V_SYN;
        V_SYN:   if (line_next == V_BACK_AT)  state_next = V_BACK;
        V_BACK:  if (line_next == '0)         state_next = V_ACT;
        default: state_next = V_ACT;
      endcase
    end
  end

  assign vblank = (state != V_ACT);

  // Lines spent in blanking; holds at its maximum rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      VBout <= '0;
    end else if (SyncVB) begin
      VBout <= '0;
    end else if (IncLine && vblank && (VBout != VB_MAX)) begin
      VBout <= VBout + 1'b1;
    end
  end

`ifdef DISP_SYNC_OUT_EN
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);

  // Syncs are sampled from the already-updated counter/state registers, so
  // they trail Pxout and the vertical phase by one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
    end else begin
      hsync_n <= !((Pxout >= HS_START) && (Pxout < HS_END));
      vsync_n <= (state != V_SYN);
    end
  end
`else
  assign hsync_n = 1'b1;
  assign vsync_n = 1'b1;
`endif

endmodule

// File: tb/tb_display_timing_counters.sv
// tb_display_timing_counters
// Directed plus randomized stimulus for display_timing_counters, checked
// against a plain arithmetic model of the counters and frame phases.
// Honours DISP_SYNC_OUT_EN the same way the design does.
module tb_display_timing_counters;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 640 + 16 + 96 + 48;
  localparam int HS_LO    = 640 + 16;
  localparam int HS_HI    = 640 + 16 + 96;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 480 + 10 + 2 + 33;
  localparam int VB_MAX   = V_TOTAL - V_ACTIVE;

  logic       clock;
  logic       reset;
  logic       IncPx, ResetPx, IncLine, ResetLine, SyncVB;
  logic       IncAddr0, ResetAddr0, IncAddr1, ResetAddr1;
  logic [9:0] Pxout, Lineout, VBout, AIPout, AILout;
  logic       line_done, frame_done, addr0_wrap, addr1_wrap;
  logic       hsync_n, vsync_n, vblank;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state. Phase: 0 active, 1 front porch, 2 sync, 3 back porch.
  int m_px, m_line, m_vb, m_a0, m_a1, m_phase;
  int m_line_done, m_frame_done, m_a0_wrap, m_a1_wrap;
  int m_hsync_n, m_vsync_n;
  int phase_end[4] = '{480, 490, 492, 0};

  display_timing_counters dut (
    .clock      (clock),
    .reset      (reset),
    .IncPx      (IncPx),
    .ResetPx    (ResetPx),
    .IncLine    (IncLine),
    .ResetLine  (ResetLine),
    .SyncVB     (SyncVB),
    .IncAddr0   (IncAddr0),
    .ResetAddr0 (ResetAddr0),
    .IncAddr1   (IncAddr1),
    .ResetAddr1 (ResetAddr1),
    .Pxout      (Pxout),
    .Lineout    (Lineout),
    .VBout      (VBout),
    .AIPout     (AIPout),
    .AILout     (AILout),
    .line_done  (line_done),
    .frame_done (frame_done),
    .addr0_wrap (addr0_wrap),
    .addr1_wrap (addr1_wrap),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .vblank     (vblank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic modelReset();
    m_px = 0; m_line = 0; m_vb = 0; m_a0 = 0; m_a1 = 0; m_phase = 0;
    m_line_done = 0; m_frame_done = 0; m_a0_wrap = 0; m_a1_wrap = 0;
    m_hsync_n = 1; m_vsync_n = 1;
  endtask

  // One clock of the model, expressed as modular arithmetic on counts.
  task automatic modelStep(input logic ipx, rpx, il, rl, svb, ia0, ra0, ia1, ra1);
    int old_px    = m_px;
    int old_phase = m_phase;
`ifdef DISP_SYNC_OUT_EN
    m_hsync_n = (old_px >= HS_LO && old_px < HS_HI) ? 0 : 1;
    m_vsync_n = (old_phase == 2) ? 0 : 1;
`else
    m_hsync_n = 1;
    m_vsync_n = 1;
`endif
    m_line_done = 0; m_frame_done = 0; m_a0_wrap = 0; m_a1_wrap = 0;
    if (rpx) m_px = 0;
    else if (ipx) begin m_px = (m_px + 1) % H_TOTAL; m_line_done = (m_px == 0); end
    if (rl) m_line = 0;
    else if (il) begin m_line = (m_line + 1) % V_TOTAL; m_frame_done = (m_line == 0); end
    if (ra0) m_a0 = 0;
    else if (ia0) begin m_a0 = (m_a0 + 1) % H_ACTIVE; m_a0_wrap = (m_a0 == 0); end
    if (ra1) m_a1 = 0;
    else if (ia1) begin m_a1 = (m_a1 + 1) % H_ACTIVE; m_a1_wrap = (m_a1 == 0); end
    if (rl) m_phase = 0;
    else if (svb) m_phase = 1;
    else if (il && m_line == phase_end[old_phase]) m_phase = (old_phase + 1) % 4;
    if (svb) m_vb = 0;
    else if (il && old_phase != 0 && m_vb < VB_MAX) m_vb = m_vb + 1;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("Pxout",      Pxout,             10'(m_px));
    checkOutput("Lineout",    Lineout,           10'(m_line));
    checkOutput("VBout",      VBout,             10'(m_vb));
    checkOutput("AIPout",     AIPout,            10'(m_a0));
    checkOutput("AILout",     AILout,            10'(m_a1));
    checkOutput("line_done",  {9'd0, line_done}, 10'(m_line_done));
    checkOutput("frame_done", {9'd0, frame_done},10'(m_frame_done));
    checkOutput("addr0_wrap", {9'd0, addr0_wrap},10'(m_a0_wrap));
    checkOutput("addr1_wrap", {9'd0, addr1_wrap},10'(m_a1_wrap));
    checkOutput("hsync_n",    {9'd0, hsync_n},   10'(m_hsync_n));
    checkOutput("vsync_n",    {9'd0, vsync_n},   10'(m_vsync_n));
    checkOutput("vblank",     {9'd0, vblank},    10'(m_phase != 0));
  endtask

  // Drive one cycle of strobes, clock it, advance the model, then compare.
  task automatic applyStimulus(input logic ipx, rpx, il, rl, svb, ia0, ra0, ia1, ra1);
    IncPx = ipx; ResetPx = rpx; IncLine = il; ResetLine = rl; SyncVB = svb;
    IncAddr0 = ia0; ResetAddr0 = ra0; IncAddr1 = ia1; ResetAddr1 = ra1;
    @(posedge clock);
    #1;
    modelStep(ipx, rpx, il, rl, svb, ia0, ra0, ia1, ra1);
    checkAll();
  endtask

  initial begin
    int pulses;
    int low_cycles;
    int exp_hs_low;
    int exp_vs_low;

`ifdef DISP_SYNC_OUT_EN
    exp_hs_low = HS_HI - HS_LO;
    exp_vs_low = 2;
`else
    exp_hs_low = 0;
    exp_vs_low = 0;
`endif

    reset = 1'b0;
    {IncPx, ResetPx, IncLine, ResetLine, SyncVB} = '0;
    {IncAddr0, ResetAddr0, IncAddr1, ResetAddr1} = '0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    $display("[TB] reset values");
    checkAll();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // A full line of pixels: one wrap pulse, hsync window seen one cycle late.
    $display("[TB] full line of IncPx");
    pulses = 0; low_cycles = 0;
    for (int i = 0; i < H_TOTAL + 1; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      if (line_done) pulses++;
      if (!hsync_n) low_cycles++;
    end
    checkOutput("line_done_count", 10'(pulses), 10'd1);
    checkOutput("hsync_low_cycles", 10'(low_cycles), 10'(exp_hs_low));

    // A full frame of lines: phases, vsync width, VB saturation, frame wrap.
    $display("[TB] full frame of IncLine");
    pulses = 0; low_cycles = 0;
    for (int i = 0; i < V_TOTAL; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
      if (frame_done) pulses++;
      if (!vsync_n) low_cycles++;
    end
    checkOutput("frame_done_count", 10'(pulses), 10'd1);
    checkOutput("vb_saturated", VBout, 10'(VB_MAX));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (!vsync_n) low_cycles++;
    checkOutput("vsync_low_lines", 10'(low_cycles), 10'(exp_vs_low));

    // Reset beats increment on address 0.
    $display("[TB] address reset-over-inc and wrap");
    for (int i = 0; i < 300; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("aip_at_300", AIPout, 10'd300);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("aip_cleared", AIPout, 10'd0);
    checkOutput("addr0_no_wrap", {9'd0, addr0_wrap}, 10'd0);

    // Address 1 wraps at 639 without touching address 0.
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < H_ACTIVE - 1; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("ail_at_639", AILout, 10'd639);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("ail_wrapped", AILout, 10'd0);
    checkOutput("addr1_wrap_pulse", {9'd0, addr1_wrap}, 10'd1);
    checkOutput("aip_unaffected", AIPout, 10'd5);

    // Mid-frame asynchronous reset at Pxout=500, Lineout=490.
    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) applyStimulus(1, 0, (i < 490), 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pre_reset_px", Pxout, 10'd500);
    checkOutput("pre_reset_line", Lineout, 10'd490);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(posedge clock);
    #1;
    checkAll();
    reset = 1'b1;
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("resume_px", Pxout, 10'd1);

    // Randomized strobes, clears and SyncVB kept rare so counters travel far.
    $display("[TB] randomized strobes");
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(
        ($urandom_range(3, 0) != 0),
        ($urandom_range(255, 0) == 0),
        ($urandom_range(1, 0) == 0),
        ($urandom_range(511, 0) == 0),
        ($urandom_range(255, 0) == 0),
        ($urandom_range(3, 0) != 0),
        ($urandom_range(127, 0) == 0),
        ($urandom_range(1, 0) == 0),
        ($urandom_range(63, 0) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
